// File: rtl/mux21_rr_arbiter_if.sv
// rtl/mux21_rr_arbiter_if.sv - requester/downstream bundle for the mux21 round-robin arbiter
interface mux21_rr_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              req0;
    logic [DATA_W-1:0] data0;
    logic              gnt0;
    logic              req1;
    logic [DATA_W-1:0] data1;
    logic              gnt1;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              sel;

    // Arbiter side: consumes requests and downstream ready, drives grants and the muxed stream.
    modport slave (
        input  req0, data0, req1, data1, out_ready,
        output gnt0, gnt1, out_valid, out_data, sel
    );

    // Environment side: requesters and downstream sink.
    modport master (
        output req0, data0, req1, data1, out_ready,
        input  gnt0, gnt1, out_valid, out_data, sel
    );
endinterface

// File: rtl/mux21_rr_arbiter.sv
// rtl/mux21_rr_arbiter.sv - round-robin arbiter and select sequencer for the shared 2:1 mux
module mux21_rr_arbiter #(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mux21_rr_arbiter_if.slave    bus
);
    localparam int              CNT_W    = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               sel_q, sel_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               serve0;
    logic               serve1;
    logic               burst_full;
    logic [DATA_W-1:0]  mux_data;

    assign serve0     = (state_q == SERVE0);
    assign serve1     = (state_q == SERVE1);
    // The burst quota is used up once the beat at index MAX_HOLD-1 is accepted.
    assign burst_full = (cnt_q == CNT_LAST);

    // State registers; reset makes requester 0 win the first tie (last=1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: pick a side from IDLE, count beats, hand over on quota or on request drop.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.req0 && bus.req1) begin
                    state_d = last_q ? SERVE0 : SERVE1;
                end else if (bus.req0) begin
                    state_d = SERVE0;
                end else if (bus.req1) begin
                    state_d = SERVE1;
                end
            end

            SERVE0: begin
                if (!bus.req0) begin
                    // Requester left: hand over (or go idle) at the cost of one bubble.
                    state_d = bus.req1 ? SERVE1 : IDLE;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                end else if (bus.out_ready) begin
                    if (burst_full && bus.req1) begin
                        state_d = SERVE1;
                        cnt_d   = '0;
                        last_d  = 1'b0;
                    end else if (!burst_full) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            SERVE1: begin
                if (!bus.req1) begin
                    state_d = bus.req0 ? SERVE0 : IDLE;
                    cnt_d   = '0;
                    last_d  = 1'b1;
                end else if (bus.out_ready) begin
                    if (burst_full && bus.req0) begin
                        state_d = SERVE0;
                        cnt_d   = '0;
                        last_d  = 1'b1;
                    end else if (!burst_full) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Select follows the state it will be in, so it is glitch-free out of a flop.
        sel_d = (state_d == SERVE1);
    end

    // Datapath and handshake outputs; grants are only possible when the beat is actually taken.
    always_comb begin
        mux_data      = sel_q ? bus.data1 : bus.data0;
        bus.out_data  = mux_data;
        bus.sel       = sel_q;
        bus.out_valid = (serve0 && bus.req0) || (serve1 && bus.req1);
        bus.gnt0      = serve0 && bus.req0 && bus.out_ready;
        bus.gnt1      = serve1 && bus.req1 && bus.out_ready;
    end
endmodule

// File: tb/tb_mux21_rr_arbiter.sv
// tb/tb_mux21_rr_arbiter.sv - directed self-checking bench for mux21_rr_arbiter
module tb_mux21_rr_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mux21_rr_arbiter_if #(.DATA_W(8)) bus ();

    mux21_rr_arbiter #(.DATA_W(8), .MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic g0, input logic g1,
                           input logic s, input logic [7:0] d);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, ".gnt0"},      32'(bus.gnt0),      32'(g0));
        chk({tag, ".gnt1"},      32'(bus.gnt1),      32'(g1));
        chk({tag, ".sel"},       32'(bus.sel),       32'(s));
        chk({tag, ".out_data"},  32'(bus.out_data),  32'(d));
    endtask

    // Advance to just after the next rising edge; inputs are changed here, checks follow after #1.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.data0 = 8'h11;
        bus.data1 = 8'h22;
        bus.out_ready = 1'b0;

        tick(); tick();
        #1;
        chk_all("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0, 8'h11);
        rst = 1'b0;

        // Single requester from IDLE: first beat one cycle after req rises.
        tick();
        bus.req0 = 1'b1; bus.data0 = 8'hA5; bus.out_ready = 1'b1;
        #1;
        chk_all("single_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
        for (int i = 0; i < 6; i++) begin
            tick(); #1;
            chk_all($sformatf("single_beat%0d", i), 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
        end

        // Contention: cnt is saturated, so req1 rising takes over right after this beat.
        tick();
        bus.req1 = 1'b1; bus.data1 = 8'h5A;
        #1;
        chk_all("contend_switch", 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
        for (int i = 0; i < 8; i++) begin
            tick(); #1;
            if (i < 4) chk_all($sformatf("contend%0d", i), 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A);
            else       chk_all($sformatf("contend%0d", i), 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
        end

        // Backpressure in SERVE1 after one accepted beat: cnt must stay at 1.
        tick(); #1;
        chk_all("bp_first", 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A);
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.out_ready = 1'b0;
            #1;
            chk_all($sformatf("bp_stall%0d", i), 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A);
        end
        tick();
        bus.out_ready = 1'b1;
        #1;
        chk_all("bp_resume0", 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A);
        tick(); #1;
        chk_all("bp_resume1", 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A);
        tick(); #1;
        chk_all("bp_resume2", 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A);
        tick(); #1;
        chk_all("bp_handover", 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);

        // Finish the SERVE0 burst, take one SERVE1 beat, then drop req1.
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk_all($sformatf("pre_drop0_%0d", i), 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
        end
        tick(); #1;
        chk_all("pre_drop1", 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A);
        tick();
        bus.req1 = 1'b0;
        #1;
        chk_all("drop_bubble", 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A);
        tick(); #1;
        chk_all("drop_serve0", 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);

        // End the req0 burst (last=0), then a tie from IDLE must go to requester 1.
        tick();
        bus.req0 = 1'b0;
        #1;
        chk_all("tie_bubble", 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
        tick();
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        #1;
        chk_all("tie_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
        tick(); #1;
        chk_all("tie_serve1", 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A);

        // Asynchronous reset mid-burst clears outputs before the next edge.
        tick();
        rst = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
        rst = 1'b0;
        // Post-reset tie goes to requester 0 since last resets to 1.
        tick(); #1;
        chk_all("post_rst_tie", 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
